// File: rtl/serial_subtractor32.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, borrow rippled across cycles.
// Results (diff, bout, ovf) update only on the completing edge and hold until the next completion.
module serial_subtractor32 #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
            $error("serial_subtractor32: DIGIT must evenly divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] part_nxt;
    logic             borrow_q;
    logic [KW-1:0]    k_q;
    logic [DIGIT:0]   slice_sub;
    logic             last;
    logic             accept;

    // One extra bit on the slice difference: its MSB is the borrow out of the slice.
    always_comb begin
        slice_sub = {1'b0, a_q[k_q*DIGIT +: DIGIT]}
                  - {1'b0, b_q[k_q*DIGIT +: DIGIT]}
                  - {{DIGIT{1'b0}}, borrow_q};
        part_nxt = part_q;
        part_nxt[k_q*DIGIT +: DIGIT] = slice_sub[DIGIT-1:0];
    end

    assign last   = (k_q == K_LAST);
    assign accept = start && (state != S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            borrow_q <= 1'b0;
            k_q      <= '0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            part_q   <= '0;
            k_q      <= '0;
        end else if (state == S_RUN) begin
            part_q   <= part_nxt;
            borrow_q <= slice_sub[DIGIT];
            if (!last) begin
                k_q <= k_q + KW'(1);
            end else begin
                // Publish only the fully assembled result; partials stay internal.
                diff <= part_nxt;
                bout <= slice_sub[DIGIT];
                ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (part_nxt[WIDTH-1] != a_q[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor32.sv
// Directed-vector and sequence bench for serial_subtractor32 (default WIDTH=32, DIGIT=4).
module tb_serial_subtractor32;

    localparam int WIDTH = 32;
    localparam int DIGIT = 4;
    localparam int LAT   = WIDTH / DIGIT;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t tbl[9];
    vec_t bb[4];

    serial_subtractor32 #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Golden model: {ovf, bout, diff}.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] r;
        r = {1'b0, x} - {1'b0, y} - {32'd0, c};
        return {((x[31] != y[31]) && (r[31] != x[31])), r};
    endfunction

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin,
                         output logic [31:0] rd, output logic rb, output logic ro,
                         output int lat, output int nbusy);
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; bin = ~tbin;
        lat = 0;
        nbusy = 0;
        while (!done && lat < 4 * LAT) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        rd = diff; rb = bout; ro = ovf;
    endtask

    initial begin
        logic [31:0] rd;
        logic        rb;
        logic        ro;
        logic [33:0] m;
        logic [31:0] ra;
        logic [31:0] rbv;
        logic        rc;
        int          lat;
        int          nbusy;
        int          ndone;
        int          done_at;
        int          last_done;

        tbl[0] = '{32'h10010010, 32'h01111111, 1'b0, 32'h0EEFEEFF, 1'b0, 1'b0};
        tbl[1] = '{32'h01111111, 32'h10010010, 1'b0, 32'hF1101101, 1'b1, 1'b0};
        tbl[2] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[3] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
        tbl[4] = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[5] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 1'b0};
        tbl[6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
        tbl[7] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[8] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk("rst_diff", diff, 32'h0);
        chk_b("rst_bout", bout, 1'b0);
        chk_b("rst_ovf", ovf, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].bin, rd, rb, ro, lat, nbusy);
            chk("tbl_diff", rd, tbl[i].diff);
            chk_b("tbl_bout", rb, tbl[i].bout);
            chk_b("tbl_ovf", ro, tbl[i].ovf);
            chk_i("tbl_latency", lat, LAT);
            chk_i("tbl_busy_cycles", nbusy, LAT);
        end

        // Start pulsed mid-run and operands churning every cycle.
        @(negedge clk);
        a = 32'h10010010; b = 32'h01111111; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        done_at = -1;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) chk("hs_diff_hold", diff, tbl[8].diff);
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = i;
                chk("hs_diff", diff, 32'h0EEFEEFF);
            end
            a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
            start = (i == 3);
            @(negedge clk);
        end
        start = 1'b0;
        chk_i("hs_done_count", ndone, 1);
        chk_i("hs_done_cycle", done_at, LAT);
        chk_b("hs_idle_busy", busy, 1'b0);

        // Back-to-back with start held high.
        bb[0] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b0, 1'b0};
        bb[1] = '{32'h00000005, 32'h00000009, 1'b1, 32'h0, 1'b0, 1'b0};
        bb[2] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h0, 1'b0, 1'b0};
        bb[3] = '{32'hCAFEF00D, 32'h12345678, 1'b1, 32'h0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            m = model(bb[i].a, bb[i].b, bb[i].bin);
            bb[i].diff = m[31:0]; bb[i].bout = m[32]; bb[i].ovf = m[33];
        end
        @(negedge clk);
        a = bb[0].a; b = bb[0].b; bin = bb[0].bin; start = 1'b1;
        ndone = 0;
        last_done = -1;
        for (int i = 0; i < 80 && ndone < 4; i++) begin
            @(negedge clk);
            if (done) begin
                chk("bb_diff", diff, bb[ndone].diff);
                chk_b("bb_bout", bout, bb[ndone].bout);
                chk_b("bb_ovf", ovf, bb[ndone].ovf);
                if (ndone > 0) chk_i("bb_period", i - last_done, LAT + 1);
                last_done = i;
                ndone++;
                if (ndone < 4) begin
                    a = bb[ndone].a; b = bb[ndone].b; bin = bb[ndone].bin;
                end
            end
        end
        start = 1'b0;
        chk_i("bb_done_count", ndone, 4);

        // Reset while slice 4 is being processed.
        @(negedge clk);
        a = 32'h01234567; b = 32'h89ABCDEF; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_b("mid_rst_busy", busy, 1'b0);
        chk_b("mid_rst_done", done, 1'b0);
        chk("mid_rst_diff", diff, 32'h0);
        chk_b("mid_rst_bout", bout, 1'b0);
        chk_b("mid_rst_ovf", ovf, 1'b0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk_i("mid_rst_no_done", ndone, 0);
        do_op(tbl[1].a, tbl[1].b, tbl[1].bin, rd, rb, ro, lat, nbusy);
        chk("post_rst_diff", rd, tbl[1].diff);
        chk_b("post_rst_bout", rb, tbl[1].bout);
        chk_b("post_rst_ovf", ro, tbl[1].ovf);
        chk_i("post_rst_latency", lat, LAT);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom; rbv = $urandom; rc = 1'($urandom_range(0, 1));
            if (n % 10 == 0) rbv = ra;
            m = model(ra, rbv, rc);
            do_op(ra, rbv, rc, rd, rb, ro, lat, nbusy);
            chk("rnd_diff", rd, m[31:0]);
            chk_b("rnd_bout", rb, m[32]);
            chk_b("rnd_ovf", ro, m[33]);
            chk_i("rnd_latency", lat, LAT);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
